// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
//   Definitions shared by the sequential multiplier and its bench:
//   - state_t      : FSM encoding {IDLE, RUN, FIX} (2-bit)
//   - MUL_SIGNED / MUL_UNSIGNED : values of the sign_mode input
//   - cnt_width()  : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic MUL_SIGNED   = 1'b1;
    localparam logic MUL_UNSIGNED = 1'b0;

    // Counter must be able to hold 0..width (it wraps to width after the last
    // iteration), hence $clog2(width+1).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_abs_neg.sv
// -----------------------------------------------------------------------------
// mul_abs_neg
//   Combinational conditional two's complement: result = negate ? -value : value.
//   Used both for operand magnitudes (N=WIDTH) and for the final sign fix-up
//   of the product (N=2*WIDTH).
// Ports
//   value   in  N  operand
//   negate  in  1  1 = return the two's complement of value
//   result  out N  value or -value
// -----------------------------------------------------------------------------
module mul_abs_neg #(
    parameter int N = 32
) (
    input  logic [N-1:0] value,
    input  logic         negate,
    output logic [N-1:0] result
);

    assign result = negate ? (~value + N'(1)) : value;

endmodule

// File: rtl/seq_mul_unit.sv
// -----------------------------------------------------------------------------
// seq_mul_unit
//   Radix-2 shift-add multiplier for the HI/LO datapath (MULT / MULTU).
//   An operation is accepted on the edge that samples start while idle; the
//   engine then iterates once per bit of b and finishes with a sign fix-up
//   cycle, after which hi/lo are updated and done pulses for one cycle.
//
// Parameters
//   WIDTH      operand width (even, 4..64); product is 2*WIDTH bits
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   start      in   1      request, sampled only while busy==0
//   sign_mode  in   1      1 = signed (MULT), 0 = unsigned (MULTU)
//   a          in   WIDTH  multiplicand
//   b          in   WIDTH  multiplier
//   abort      in   1      flush: kills the in-flight operation, no done
//   busy       out  1      operation in flight
//   done       out  1      one-cycle pulse, hi/lo valid
//   hi         out  WIDTH  upper half of the product
//   lo         out  WIDTH  lower half of the product
//
// Configuration
//   SEQ_MUL_ZERO_SKIP_EN : when defined, an operation whose sampled a or b is
//   zero jumps straight from IDLE to FIX (result 0, done one edge later).
// -----------------------------------------------------------------------------
module seq_mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]     acc_reg;
    logic [WIDTH-1:0]       mcand_reg;
    logic [WIDTH-1:0]       mplier_reg;
    logic                   neg_reg;
    logic                   done_reg;
    logic [WIDTH-1:0]       hi_reg;
    logic [WIDTH-1:0]       lo_reg;

    logic                   accept;
    logic                   finish;
    logic                   neg_next;
    logic [WIDTH:0]         add_sum;
    logic [2*WIDTH-1:0]     acc_shift;
    logic [2*WIDTH-1:0]     product;

    logic [WIDTH-1:0]       operand   [2];
    logic [WIDTH-1:0]       magnitude [2];

    assign operand[0] = a;
    assign operand[1] = b;

    // Operand magnitudes: only negate when in signed mode and the MSB is set.
    // -2^(WIDTH-1) maps to itself, which is the correct unsigned magnitude.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mag
            mul_abs_neg #(.N(WIDTH)) u_mag (
                .value  (operand[gi]),
                .negate ((sign_mode == MUL_SIGNED) && operand[gi][WIDTH-1]),
                .result (magnitude[gi])
            );
        end
    endgenerate

    assign neg_next = (sign_mode == MUL_SIGNED) && (a[WIDTH-1] ^ b[WIDTH-1]);

    mul_abs_neg #(.N(2*WIDTH)) u_fix (
        .value  (acc_reg),
        .negate (neg_reg),
        .result (product)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                // abort wins over start in the same cycle
                if (start && !abort) begin
                    accept     = 1'b1;
                    state_next = RUN;
`ifdef SEQ_MUL_ZERO_SKIP_EN
                    // accumulator is cleared on accept, so FIX yields zero
                    if ((a == '0) || (b == '0)) begin
                        state_next = FIX;
                    end
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                finish     = !abort;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- shift-add datapath ----------------
    // Add the multiplicand into the upper half (keeping the carry), then shift
    // {carry, acc} right by one. After WIDTH steps acc holds |a|*|b|.
    always_comb begin
        add_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + {1'b0, (mplier_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
        acc_shift = {add_sum, acc_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            done_reg <= finish;
            if (accept) begin
                mcand_reg  <= magnitude[0];
                mplier_reg <= magnitude[1];
                neg_reg    <= neg_next;
                acc_reg    <= '0;
                cnt_reg    <= '0;
            end else if (state_reg == RUN && !abort) begin
                acc_reg    <= acc_shift;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CNT_W'(1);
            end
            if (finish) begin
                hi_reg <= product[2*WIDTH-1:WIDTH];
                lo_reg <= product[WIDTH-1:0];
            end
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_seq_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_unit
//   Directed checks of seq_mul_unit at WIDTH=32 (arithmetic corners, latency,
//   busy/start rules, abort, reset mid-operation, zero operands) plus a sweep of
//   a WIDTH=8 instance against a behavioural a*b reference.
// -----------------------------------------------------------------------------
module tb_seq_mul_unit;
    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sign_mode = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8 = 1'b0;
    logic        sign_mode8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        abort8 = 1'b0;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_mul_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .sign_mode(sign_mode),
        .a(a), .b(b), .abort(abort),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    seq_mul_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sign_mode(sign_mode8),
        .a(a8), .b(b8), .abort(abort8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

`ifdef SEQ_MUL_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    // Issue one operation on the 32-bit unit (called #1 after an edge, unit
    // idle). Returns the result, edges from accept to done (100 on timeout)
    // and the number of cycles busy was seen high.
    task automatic do_op32(input logic [31:0] op_a, input logic [31:0] op_b,
                           input logic mode, output logic [31:0] r_hi,
                           output logic [31:0] r_lo, output int edges,
                           output int busy_cnt);
        a = op_a; b = op_b; sign_mode = mode; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        edges = 100;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                edges = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        r_hi = hi; r_lo = lo;
    endtask

    task automatic do_op8(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic mode, output logic [15:0] res,
                          output int edges);
        a8 = op_a; b8 = op_b; sign_mode8 = mode; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 50;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                edges = i;
                break;
            end
        end
        res = {hi8, lo8};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
        reset = 1'b0;
        @(posedge clk); #1;
        $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    endtask

    task automatic test_arith();
        logic [31:0] va   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000,
                                  32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [31:0] vb   [7] = '{32'hFFFFFFFF, 32'h00000007, 32'h00000002,
                                  32'h00000007, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        logic        vm   [7] = '{MUL_UNSIGNED, MUL_UNSIGNED, MUL_UNSIGNED,
                                  MUL_SIGNED, MUL_SIGNED, MUL_SIGNED, MUL_SIGNED};
        logic [31:0] e_hi [7] = '{32'hFFFFFFFE, 32'h00000006, 32'h00000001,
                                  32'hFFFFFFFF, 32'h40000000, 32'h00000000, 32'hC0000000};
        logic [31:0] e_lo [7] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000,
                                  32'hFFFFFFEB, 32'h00000000, 32'h00000001, 32'h80000000};
        logic [31:0] r_hi, r_lo;
        int edges, bcnt;
        for (int i = 0; i < 7; i++) begin
            do_op32(va[i], vb[i], vm[i], r_hi, r_lo, edges, bcnt);
            $display("op%0d: a=%h b=%h signed=%b -> hi=%h lo=%h edges=%0d busy_cycles=%0d",
                     i, va[i], vb[i], vm[i], r_hi, r_lo, edges, bcnt);
            total++; if (r_hi !== e_hi[i]) begin bad++; $display("FAIL arith_hi[%0d] got=%h exp=%h", i, r_hi, e_hi[i]); end
            total++; if (r_lo !== e_lo[i]) begin bad++; $display("FAIL arith_lo[%0d] got=%h exp=%h", i, r_lo, e_lo[i]); end
            total++; if (edges != 33) begin bad++; $display("FAIL arith_latency[%0d] got=%0d exp=33", i, edges); end
            total++; if (bcnt != 33) begin bad++; $display("FAIL arith_busy_cycles[%0d] got=%0d exp=33", i, bcnt); end
        end
    endtask

    task automatic test_busy_rules();
        int idx, done_cnt, edges;
        // first op 3*5, stray start 5 edges after accept must be ignored
        a = 32'd3; b = 32'd5; sign_mode = MUL_UNSIGNED; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a = 32'd100; b = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 5; done_cnt = 0;
        while (idx < 100 && !done) begin
            @(posedge clk); #1;
            idx++;
        end
        $display("busy_rules first: done_at=%0d hi=%h lo=%h", idx, hi, lo);
        total++; if (idx != 33) begin bad++; $display("FAIL busy_first_latency got=%0d exp=33", idx); end
        total++; if ({hi, lo} !== 64'd15) begin bad++; $display("FAIL busy_first_result got=%h exp=%h", {hi, lo}, 64'd15); end
        // start in the done cycle is accepted
        a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_done_cycle_accept got=%b exp=1", busy); end
        edges = 100;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin edges = i; break; end
        end
        $display("busy_rules second: edges=%0d hi=%h lo=%h", edges, hi, lo);
        total++; if (edges != 33) begin bad++; $display("FAIL busy_second_latency got=%0d exp=33", edges); end
        total++; if ({hi, lo} !== 64'd42) begin bad++; $display("FAIL busy_second_result got=%h exp=%h", {hi, lo}, 64'd42); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL busy_no_queued_op got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_abort();
        logic [31:0] r_hi, r_lo;
        int edges, bcnt, done_cnt;
        do_op32(32'd3, 32'd5, MUL_UNSIGNED, r_hi, r_lo, edges, bcnt);
        total++; if ({r_hi, r_lo} !== 64'd15) begin bad++; $display("FAIL abort_setup got=%h exp=%h", {r_hi, r_lo}, 64'd15); end
        a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        done_cnt = done ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        $display("abort: busy=%b dones=%0d hi=%h lo=%h", busy, done_cnt, hi, lo);
        total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
        total++; if ({hi, lo} !== 64'd15) begin bad++; $display("FAIL abort_keep_result got=%h exp=%h", {hi, lo}, 64'd15); end
        // abort in IDLE together with start: start is ignored
        a = 32'd2; b = 32'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_priority got=%b exp=0", busy); end
        // unit still works after abort
        do_op32(32'd2, 32'd3, MUL_UNSIGNED, r_hi, r_lo, edges, bcnt);
        $display("after_abort: hi=%h lo=%h edges=%0d", r_hi, r_lo, edges);
        total++; if ({r_hi, r_lo} !== 64'd6) begin bad++; $display("FAIL abort_recover got=%h exp=%h", {r_hi, r_lo}, 64'd6); end
        // reset mid-RUN clears everything
        a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset_mid_run: busy=%b hi=%h lo=%h", busy, hi, lo);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_run_busy got=%b exp=0", busy); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_run_result got=%h exp=0", {hi, lo}); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_skip();
        logic [31:0] r_hi, r_lo;
        int edges, bcnt;
        do_op32(32'd9, 32'd9, MUL_UNSIGNED, r_hi, r_lo, edges, bcnt);
        do_op32(32'd0, 32'h1234, MUL_UNSIGNED, r_hi, r_lo, edges, bcnt);
        $display("zero: a=0 b=1234 -> hi=%h lo=%h edges=%0d busy_cycles=%0d", r_hi, r_lo, edges, bcnt);
        total++; if ({r_hi, r_lo} !== 64'd0) begin bad++; $display("FAIL zero_result got=%h exp=0", {r_hi, r_lo}); end
        total++; if (edges != ZERO_LAT) begin bad++; $display("FAIL zero_latency got=%0d exp=%0d", edges, ZERO_LAT); end
        total++; if (bcnt != ZERO_LAT) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=%0d", bcnt, ZERO_LAT); end
    endtask

    task automatic test_sweep8();
        logic [7:0]  ra, rb;
        logic        rm;
        logic [15:0] res, exp16;
        int edges, prod;
        for (int i = 0; i < 2000; i++) begin
            if (i == 0)      begin ra = 8'h80; rb = 8'h80; rm = MUL_SIGNED;   end
            else if (i == 1) begin ra = 8'hFF; rb = 8'hFF; rm = MUL_UNSIGNED; end
            else if (i == 2) begin ra = 8'h7F; rb = 8'h80; rm = MUL_SIGNED;   end
            else begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rm = i[0];
            end
            if (rm) prod = int'($signed(ra)) * int'($signed(rb));
            else    prod = int'(ra) * int'(rb);
            exp16 = prod[15:0];
            do_op8(ra, rb, rm, res, edges);
            $display("w8 op%0d: a=%h b=%h signed=%b -> %h exp=%h edges=%0d", i, ra, rb, rm, res, exp16, edges);
            total++; if (res !== exp16) begin bad++; $display("FAIL w8_result[%0d] got=%h exp=%h", i, res, exp16); end
            total++; if (edges != 9) begin bad++; $display("FAIL w8_latency[%0d] got=%0d exp=9", i, edges); end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_busy_rules();
        test_abort();
        test_zero_skip();
        test_sweep8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
